// File: rtl/distance_smoother.sv
// Clamp, optional median-of-3 prefilter, and power-of-2 moving average for distance samples.
// Optional build macro DISTANCE_SMOOTHER_MEDIAN3_EN adds the median stage (latency 3 instead of 2).
module distance_smoother #(
    parameter int IN_W     = 26,
    parameter int OUT_W    = 8,
    parameter int AVG_LOG2 = 2,
    parameter int MAX_CM   = 255,
    parameter int TIMEOUT  = 50000000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             sample_valid,
    input  logic [IN_W-1:0]  sample_cm,
    output logic [OUT_W-1:0] dist_out,
    output logic             dist_valid,
    output logic             stale,
    output logic             sat
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = OUT_W + AVG_LOG2;
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [IN_W-1:0]     MAX_IN   = IN_W'(MAX_CM);
    localparam logic [OUT_W-1:0]    MAX_OUT  = OUT_W'(MAX_CM);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    CNT_PRE  = CNT_W'(TIMEOUT - 2);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [AVG_LOG2-1:0] WP_ONE   = AVG_LOG2'(1);

    typedef enum logic [1:0] {EMPTY, TRACK, STALE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_nx;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx    = state;
        idle_cnt_nx = idle_cnt;
        case (state)
            EMPTY, STALE: begin
                if (sample_valid) begin
                    state_nx    = TRACK;
                    idle_cnt_nx = '0;
                end
            end
            TRACK: begin
                if (sample_valid) begin
                    idle_cnt_nx = '0;
                end else if (idle_cnt == CNT_PRE) begin
                    state_nx    = STALE;
                    idle_cnt_nx = CNT_LAST;
                end else begin
                    idle_cnt_nx = idle_cnt + CNT_ONE;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    assign stale = (state != TRACK);

    logic [OUT_W-1:0] clamped;
    logic [OUT_W-1:0] c_q;
    logic             c_valid_q;
    logic             c_prime_q;

    assign clamped = (sample_cm > MAX_IN) ? MAX_OUT : sample_cm[OUT_W-1:0];

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= EMPTY;
            idle_cnt  <= '0;
            c_q       <= '0;
            c_valid_q <= 1'b0;
            c_prime_q <= 1'b0;
            sat       <= 1'b0;
        end else begin
            state     <= state_nx;
            idle_cnt  <= idle_cnt_nx;
            c_valid_q <= sample_valid;
            if (sample_valid) begin
                c_q       <= clamped;
                c_prime_q <= (state != TRACK);
                sat       <= (sample_cm > MAX_IN);
            end
        end
    end

    logic [OUT_W-1:0] w_data;
    logic             w_valid;
    logic             w_prime;

`ifdef DISTANCE_SMOOTHER_MEDIAN3_EN
    logic [OUT_W-1:0] hist0, hist1, m_q;
    logic             m_valid_q, m_prime_q;

    function automatic logic [OUT_W-1:0] median3(input logic [OUT_W-1:0] a,
                                                 input logic [OUT_W-1:0] b,
                                                 input logic [OUT_W-1:0] c);
        if ((a >= b && a <= c) || (a <= b && a >= c))
            return a;
        else if ((b >= a && b <= c) || (b <= a && b >= c))
            return b;
        else
            return c;
    endfunction

    always_ff @(posedge clock) begin
        if (!resetn) begin
            hist0     <= '0;
            hist1     <= '0;
            m_q       <= '0;
            m_valid_q <= 1'b0;
            m_prime_q <= 1'b0;
        end else begin
            m_valid_q <= c_valid_q;
            if (c_valid_q) begin
                m_prime_q <= c_prime_q;
                hist0     <= c_q;
                if (c_prime_q) begin
                    hist1 <= c_q;
                    m_q   <= c_q;
                end else begin
                    hist1 <= hist0;
                    m_q   <= median3(c_q, hist0, hist1);
                end
            end
        end
    end

    assign w_data  = m_q;
    assign w_valid = m_valid_q;
    assign w_prime = m_prime_q;
`else
    assign w_data  = c_q;
    assign w_valid = c_valid_q;
    assign w_prime = c_prime_q;
`endif

    logic [OUT_W-1:0]    win [DEPTH];
    logic [AVG_LOG2-1:0] wp;
    logic [SUM_W-1:0]    sum, sum_nx;

    // Priming fills the whole window, so the average equals the first sample immediately.
    assign sum_nx = w_prime ? (SUM_W'(w_data) << AVG_LOG2)
                            : (sum - SUM_W'(win[wp]) + SUM_W'(w_data));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            // NOTE: the window is small and its contents feed the sum, so it is reset explicitly.
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            wp         <= '0;
            sum        <= '0;
            dist_out   <= '0;
            dist_valid <= 1'b0;
        end else begin
            dist_valid <= w_valid;
            if (w_valid) begin
                sum      <= sum_nx;
                dist_out <= sum_nx[SUM_W-1:AVG_LOG2];
                if (w_prime) begin
                    for (int i = 0; i < DEPTH; i++) win[i] <= w_data;
                    wp <= '0;
                end else begin
                    win[wp] <= w_data;
                    wp      <= wp + WP_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_distance_smoother.sv
// Self-checking bench for distance_smoother: directed table, hand sequences, and random traffic vs a queue-based model.
module tb_distance_smoother;

    localparam int IN_W  = 26;
    localparam int OUT_W = 8;
    localparam int TO    = 100;
`ifdef DISTANCE_SMOOTHER_MEDIAN3_EN
    localparam int LAT = 3;
    localparam bit MED = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit MED = 1'b0;
`endif

    logic             clock;
    logic             resetn;
    logic             sample_valid;
    logic [IN_W-1:0]  sample_cm;
    logic [OUT_W-1:0] dist_out;
    logic             dist_valid;
    logic             stale;
    logic             sat;

    distance_smoother #(
        .IN_W(IN_W), .OUT_W(OUT_W), .AVG_LOG2(2), .MAX_CM(255), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .resetn(resetn), .sample_valid(sample_valid), .sample_cm(sample_cm),
        .dist_out(dist_out), .dist_valid(dist_valid), .stale(stale), .sat(sat)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: window and median history as plain queues of clamped values.
    typedef struct { int at; int val; } exp_t;
    exp_t pend[$];
    int   hist[$];
    int   win[$];
    bit   seen;
    int   last_cyc;
    bit   m_sat;
    int   m_out;

    logic obs_dv;
    int   obs_dist;
    logic obs_stale;

    function automatic int med3(input int a, input int b, input int c);
        int lo = (a < b) ? a : b;
        int hi = (a < b) ? b : a;
        return (c < lo) ? lo : ((c > hi) ? hi : c);
    endfunction

    task automatic model_reset();
        pend.delete();
        hist.delete();
        win.delete();
        seen  = 1'b0;
        m_sat = 1'b0;
        m_out = 0;
    endtask

    task automatic model_accept(input logic [IN_W-1:0] cm);
        int c     = (cm > 255) ? 255 : int'(cm);
        bit prime = !seen || (cyc - last_cyc >= TO);
        int w     = c;
        int total = 0;
        if (MED) begin
            if (prime) hist = '{c, c, c};
            else begin
                void'(hist.pop_front());
                hist.push_back(c);
                w = med3(hist[0], hist[1], hist[2]);
            end
        end
        if (prime) win = '{w, w, w, w};
        else begin
            void'(win.pop_front());
            win.push_back(w);
        end
        foreach (win[i]) total += win[i];
        pend.push_back('{cyc + LAT, total / 4});
        seen     = 1'b1;
        last_cyc = cyc;
        m_sat    = (cm > 255);
    endtask

    task automatic model_check();
        bit exp_dv;
        obs_dv    = dist_valid;
        obs_dist  = int'(dist_out);
        obs_stale = stale;
        while (pend.size() > 0 && pend[0].at < cyc) void'(pend.pop_front());
        exp_dv = (pend.size() > 0 && pend[0].at == cyc);
        check("dist_valid", dist_valid, exp_dv);
        if (exp_dv) begin
            check("dist_out", dist_out, pend[0].val);
            m_out = pend[0].val;
            void'(pend.pop_front());
        end else begin
            check("dist_out held", dist_out, m_out);
        end
        check("stale", stale, (!seen || (cyc - last_cyc >= TO)));
        check("sat", sat, m_sat);
    endtask

    // One clock cycle: drive, sample mid-cycle, then let the model see the edge.
    task automatic tick(input bit v, input logic [IN_W-1:0] cm);
        sample_valid = v;
        sample_cm    = cm;
        @(negedge clock);
        model_check();
        @(posedge clock);
        if (v) model_accept(cm);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        sample_valid = 1'b1;
        sample_cm    = 26'd77;
        repeat (2) @(posedge clock);
        #1;
        resetn       = 1'b1;
        sample_valid = 1'b0;
        model_reset();
        check("reset dist_out", dist_out, 0);
        check("reset dist_valid", dist_valid, 0);
        check("reset stale", stale, 1);
        check("reset sat", sat, 0);
    endtask

    typedef struct {
        logic [IN_W-1:0] cm;
        int              exp_dist;
        bit              exp_sat;
    } vec_t;

    vec_t tbl[7];
    int   burst_exp[4];
    int   glitch_exp[3];
    int   edge_exp;
    int   dv_cnt;

    initial begin
        resetn       = 1'b0;
        sample_valid = 1'b0;
        sample_cm    = '0;
        model_reset();

`ifdef DISTANCE_SMOOTHER_MEDIAN3_EN
        tbl[0] = '{26'd40,  40, 1'b0};
        tbl[1] = '{26'd80,  40, 1'b0};
        tbl[2] = '{26'd80,  50, 1'b0};
        tbl[3] = '{26'd80,  60, 1'b0};
        tbl[4] = '{26'd80,  70, 1'b0};
        tbl[5] = '{26'd300, 80, 1'b1};
        tbl[6] = '{26'd100, 85, 1'b0};
        burst_exp  = '{0, 1, 3, 6};
        glitch_exp = '{40, 40, 40};
        edge_exp   = 20;
`else
        tbl[0] = '{26'd40,  40,  1'b0};
        tbl[1] = '{26'd80,  50,  1'b0};
        tbl[2] = '{26'd80,  60,  1'b0};
        tbl[3] = '{26'd80,  70,  1'b0};
        tbl[4] = '{26'd80,  80,  1'b0};
        tbl[5] = '{26'd300, 123, 1'b1};
        tbl[6] = '{26'd100, 128, 1'b0};
        burst_exp  = '{1, 3, 6, 10};
        glitch_exp = '{40, 80, 80};
        edge_exp   = 30;
`endif

        do_reset();

        // Directed table: prime, step response, saturation.
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, tbl[i].cm);
            repeat (LAT) tick(1'b0, '0);
            check("tbl dist_valid", obs_dv, 1);
            check("tbl dist_out", obs_dist, tbl[i].exp_dist);
            check("tbl sat", sat, tbl[i].exp_sat);
            check("tbl stale", stale, 0);
        end

        // Timeout: stale on the TO-th idle cycle, output held, then reprime.
        do_reset();
        tick(1'b1, 26'd40);
        for (int k = 1; k < TO; k++) tick(1'b0, '0);
        check("stale before timeout", obs_stale, 0);
        tick(1'b0, '0);
        check("stale at timeout", obs_stale, 1);
        check("held at timeout", obs_dist, 40);
        repeat (20) tick(1'b0, '0);
        check("stale persists", stale, 1);
        tick(1'b1, 26'd20);
        repeat (LAT) tick(1'b0, '0);
        check("reprime dist_valid", obs_dv, 1);
        check("reprime dist_out", obs_dist, 20);
        check("reprime stale", stale, 0);

        // Sample on the last cycle before expiry keeps tracking (no reprime).
        for (int k = 1; k < TO - LAT - 1; k++) tick(1'b0, '0);
        tick(1'b1, 26'd60);
        repeat (LAT) tick(1'b0, '0);
        check("edge sample dist_out", obs_dist, edge_exp);
        check("edge sample stale", obs_stale, 0);

        // Back-to-back burst after priming at 0.
        do_reset();
        tick(1'b1, '0);
        repeat (LAT + 1) tick(1'b0, '0);
        for (int i = 0; i <= LAT + 4; i++) begin
            tick(i < 4, IN_W'((i + 1) * 4));
            if (i >= LAT && i < LAT + 4) begin
                check("burst dist_valid", obs_dv, 1);
                check("burst dist_out", obs_dist, burst_exp[i - LAT]);
            end
        end
        check("burst end dist_valid", obs_dv, 0);

        // Reset with samples in flight: nothing emerges afterwards.
        tick(1'b1, 26'd50);
        tick(1'b1, 26'd60);
        do_reset();
        dv_cnt = 0;
        repeat (LAT + 3) begin
            tick(1'b0, '0);
            if (obs_dv) dv_cnt++;
        end
        check("no dist_valid after reset", dv_cnt, 0);

        // Single-echo glitch between two normal readings.
        tick(1'b1, 26'd40);
        repeat (LAT + 1) tick(1'b0, '0);
        for (int i = 0; i <= LAT + 2; i++) begin
            tick(i < 3, (i == 1) ? 26'd200 : 26'd40);
            if (i >= LAT) begin
                check("glitch dist_valid", obs_dv, 1);
                check("glitch dist_out", obs_dist, glitch_exp[i - LAT]);
            end
        end

        // Random traffic, including gaps straddling the timeout.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [IN_W-1:0] cm;
            int sel = $urandom_range(0, 9);
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(TO - 3, TO + 2)) tick(1'b0, '0);
            end
            if (sel == 0)      cm = IN_W'($urandom);
            else if (sel == 1) cm = 26'd255;
            else if (sel == 2) cm = 26'd256;
            else               cm = IN_W'($urandom_range(0, 300));
            tick(1'($urandom_range(0, 1)), cm);
        end
        repeat (LAT + 2) tick(1'b0, '0);
        check("all pulses seen", pend.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
